// File: rtl/grad_xy_stream.sv
// grad_xy_stream: streaming central-difference gradient unit.
// Accepts a raster-order pixel stream one pixel per cycle and emits signed
// Ix/Iy for every interior pixel of a W x H frame through a single output
// register stage with val/rdy handshakes on both sides.
// Optional feature macro: GRAD_MAG_EN adds the out_mag = |Ix|+|Iy| port.
module grad_xy_stream #(
    parameter int W  = 8,
    parameter int H  = 8,
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [DW-1:0]        in_pix,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic signed [DW:0]   out_ix,
    output logic signed [DW:0]   out_iy,
`ifdef GRAD_MAG_EN
    output logic [DW:0]          out_mag,
`endif
    output logic                 out_last
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;

    // Absolute value of a (DW+1)-bit difference; result never exceeds 2^DW-1.
    function automatic logic [DW:0] abs_diff(input logic signed [DW:0] v);
        if (v[DW]) begin
            abs_diff = -v;
        end else begin
            abs_diff = v;
        end
    endfunction

    // Position of the pixel currently offered on the input.
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // Line buffers: lb1 holds row r-1, lb2 holds row r-2 (never cleared).
    logic [DW-1:0] lb1_q [W];
    logic [DW-1:0] lb2_q [W];

    // Window taps kept from earlier columns: column c-1 (top/bottom rows)
    // and columns c-1, c-2 of the middle row. Column c comes straight from
    // the line-buffer read and in_pix.
    logic [DW-1:0] win_top_q;
    logic [DW-1:0] win_bot_q;
    logic [DW-1:0] win_mid_q [2];

    // Output register stage.
    logic                 out_val_q, out_val_d;
    logic signed [DW:0]   out_ix_q, out_ix_d;
    logic signed [DW:0]   out_iy_q, out_iy_d;
    logic                 out_last_q, out_last_d;
    logic [DW:0]          out_mag_q, out_mag_d;

    logic                 accept_s;
    logic                 qualify_s;
    logic                 col_last_s;
    logic                 row_last_s;
    logic [DW-1:0]        lb1_rd_s;
    logic [DW-1:0]        lb2_rd_s;
    logic signed [DW:0]   ix_s;
    logic signed [DW:0]   iy_s;

    assign in_rdy     = !out_val_q || out_rdy;
    assign accept_s   = in_val && in_rdy;
    assign col_last_s = (col_q == CW'(W - 1));
    assign row_last_s = (row_q == RW'(H - 1));
    assign qualify_s  = (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign lb1_rd_s   = lb1_q[col_q];
    assign lb2_rd_s   = lb2_q[col_q];

    // Exact differences of zero-extended operands around centre (r-1,c-1).
    assign ix_s = $signed({1'b0, lb1_rd_s}) - $signed({1'b0, win_mid_q[1]});
    assign iy_s = $signed({1'b0, win_bot_q}) - $signed({1'b0, win_top_q});

    // Raster counters advance only on an input transfer.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept_s) begin
            if (col_last_s) begin
                col_d = CW'(0);
                if (row_last_s) begin
                    row_d = RW'(0);
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end else begin
            col_d = col_q;
        end
    end

    // Output register next state: load on a qualifying pixel, clear on drain.
    always_comb begin
        out_val_d  = out_val_q;
        out_ix_d   = out_ix_q;
        out_iy_d   = out_iy_q;
        out_last_d = out_last_q;
        out_mag_d  = out_mag_q;
        if (accept_s && qualify_s) begin
            out_val_d  = 1'b1;
            out_ix_d   = ix_s;
            out_iy_d   = iy_s;
            out_last_d = row_last_s && col_last_s;
`ifdef GRAD_MAG_EN
            out_mag_d  = abs_diff(ix_s) + abs_diff(iy_s);
`else
            out_mag_d  = {(DW+1){1'b0}};
`endif
        end else if (accept_s) begin
            out_val_d = 1'b0;
        end else if (out_rdy) begin
            out_val_d = 1'b0;
        end else begin
            out_val_d = out_val_q;
        end
    end

    // Counter and output register state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q      <= CW'(0);
            row_q      <= RW'(0);
            out_val_q  <= 1'b0;
            out_ix_q   <= '0;
            out_iy_q   <= '0;
            out_last_q <= 1'b0;
            out_mag_q  <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            out_val_q  <= out_val_d;
            out_ix_q   <= out_ix_d;
            out_iy_q   <= out_iy_d;
            out_last_q <= out_last_d;
            out_mag_q  <= out_mag_d;
        end
    end

    // Line buffers and window shift on each accepted pixel; no reset needed
    // because rows 0-1 of every frame never produce an output.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb2_q[col_q] <= lb1_rd_s;
            lb1_q[col_q] <= in_pix;
            win_top_q    <= lb2_rd_s;
            win_bot_q    <= in_pix;
            win_mid_q[1] <= win_mid_q[0];
            win_mid_q[0] <= lb1_rd_s;
        end
    end

    assign out_val  = out_val_q;
    assign out_ix   = out_ix_q;
    assign out_iy   = out_iy_q;
    assign out_last = out_last_q;
`ifdef GRAD_MAG_EN
    assign out_mag  = out_mag_q;
`else
    logic unused_mag_s;
    assign unused_mag_s = ^{out_mag_q, abs_diff(ix_s)};
`endif

endmodule

// File: tb/tb_grad_xy_stream.sv
// Directed testbench for grad_xy_stream with W=H=5, DW=8.
`timescale 1ns/1ps
module tb_grad_xy_stream;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int DW = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_val;
    logic                in_rdy;
    logic [DW-1:0]       in_pix;
    logic                out_val;
    logic                out_rdy;
    logic signed [DW:0]  out_ix;
    logic signed [DW:0]  out_iy;
    logic                out_last;
`ifdef GRAD_MAG_EN
    logic [DW:0]         out_mag;
`endif

    int errors = 0;
    int checks = 0;
    int stalls = 0;

    logic [DW:0] q_ix[$];
    logic [DW:0] q_iy[$];
    logic        q_last[$];
    logic [DW:0] q_mag[$];

    grad_xy_stream #(.W(W), .H(H), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_pix   (in_pix),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_ix   (out_ix),
        .out_iy   (out_iy),
`ifdef GRAD_MAG_EN
        .out_mag  (out_mag),
`endif
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    // Record every output transfer, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && out_val && out_rdy) begin
            q_ix.push_back(out_ix);
            q_iy.push_back(out_iy);
            q_last.push_back(out_last);
`ifdef GRAD_MAG_EN
            q_mag.push_back(out_mag);
`else
            q_mag.push_back('0);
`endif
        end
    end

    function automatic logic [DW-1:0] pix_of(input int mode, input int idx);
        int r, c, f;
        r = (idx / W) % H;
        c = idx % W;
        f = idx / (W * H);
        case (mode)
            0: pix_of = DW'(c);
            1: pix_of = DW'(10 * r);
            2: pix_of = (c == 0) ? 8'd255 : 8'd0;
            3: pix_of = (f == 0) ? DW'(c) : DW'(10 * r);
            default: pix_of = 8'd0;
        endcase
    endfunction

    task automatic clear_q();
        q_ix.delete();
        q_iy.delete();
        q_last.delete();
        q_mag.delete();
    endtask

    // Offer n pixels back to back; called and returns at posedge+2.
    task automatic send_pixels(input int mode, input int n);
        for (int i = 0; i < n; i++) begin
            int cyc;
            in_pix = pix_of(mode, i);
            in_val = 1'b1;
            cyc = 0;
            while (!in_rdy && cyc < 200) begin
                @(posedge clk); #2;
                cyc++;
                stalls++;
            end
            if (cyc >= 200) begin
                checks++; errors++;
                $display("FAIL send_timeout: in_rdy=%0b after %0d cycles, required 1", in_rdy, cyc);
            end
            @(posedge clk); #2;
        end
        in_val = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_val = 1'b0; in_pix = '0; out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val: got %0b want 0", out_val); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %0b want 1", in_rdy); end
        checks++; if (out_ix !== 9'h000) begin errors++; $display("FAIL reset_ix: got %h want 000", out_ix); end
        checks++; if (out_iy !== 9'h000) begin errors++; $display("FAIL reset_iy: got %h want 000", out_iy); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %0b want 0", out_last); end
`ifdef GRAD_MAG_EN
        checks++; if (out_mag !== 9'h000) begin errors++; $display("FAIL reset_mag: got %h want 000", out_mag); end
`endif
    endtask

    task automatic test_ramp_x();
        clear_q();
        send_pixels(0, 25);
        drain();
        checks++; if (q_ix.size() !== 9) begin errors++; $display("FAIL rampx_count: got %0d want 9", q_ix.size()); end
        for (int i = 0; i < q_ix.size(); i++) begin
            checks++; if (q_ix[i] !== 9'h002) begin errors++; $display("FAIL rampx_ix[%0d]: got %h want 002", i, q_ix[i]); end
            checks++; if (q_iy[i] !== 9'h000) begin errors++; $display("FAIL rampx_iy[%0d]: got %h want 000", i, q_iy[i]); end
            checks++; if (q_last[i] !== (i == 8)) begin errors++; $display("FAIL rampx_last[%0d]: got %0b want %0b", i, q_last[i], (i == 8)); end
`ifdef GRAD_MAG_EN
            checks++; if (q_mag[i] !== 9'h002) begin errors++; $display("FAIL rampx_mag[%0d]: got %h want 002", i, q_mag[i]); end
`endif
        end
    endtask

    task automatic test_ramp_y();
        clear_q();
        send_pixels(1, 25);
        drain();
        checks++; if (q_ix.size() !== 9) begin errors++; $display("FAIL rampy_count: got %0d want 9", q_ix.size()); end
        for (int i = 0; i < q_ix.size(); i++) begin
            checks++; if (q_ix[i] !== 9'h000) begin errors++; $display("FAIL rampy_ix[%0d]: got %h want 000", i, q_ix[i]); end
            checks++; if (q_iy[i] !== 9'h014) begin errors++; $display("FAIL rampy_iy[%0d]: got %h want 014", i, q_iy[i]); end
`ifdef GRAD_MAG_EN
            checks++; if (q_mag[i] !== 9'h014) begin errors++; $display("FAIL rampy_mag[%0d]: got %h want 014", i, q_mag[i]); end
`endif
        end
    endtask

    task automatic test_col_edge();
        clear_q();
        send_pixels(2, 25);
        drain();
        checks++; if (q_ix.size() !== 9) begin errors++; $display("FAIL edge_count: got %0d want 9", q_ix.size()); end
        for (int i = 0; i < q_ix.size(); i++) begin
            logic [DW:0] exp_ix;
            exp_ix = ((i % 3) == 0) ? 9'h101 : 9'h000;
            checks++; if (q_ix[i] !== exp_ix) begin errors++; $display("FAIL edge_ix[%0d]: got %h want %h", i, q_ix[i], exp_ix); end
            checks++; if (q_iy[i] !== 9'h000) begin errors++; $display("FAIL edge_iy[%0d]: got %h want 000", i, q_iy[i]); end
`ifdef GRAD_MAG_EN
            begin
                logic [DW:0] exp_mag;
                exp_mag = ((i % 3) == 0) ? 9'h0FF : 9'h000;
                checks++; if (q_mag[i] !== exp_mag) begin errors++; $display("FAIL edge_mag[%0d]: got %h want %h", i, q_mag[i], exp_mag); end
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        clear_q();
        fork
            send_pixels(0, 25);
            begin
                int cyc;
                cyc = 0;
                while (!out_val && cyc < 100) begin
                    @(posedge clk); #1;
                    cyc++;
                end
                checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL bp_first_out: out_val=%0b want 1", out_val); end
                out_rdy = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    #0.5;
                    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_rdy[%0d]: got %0b want 0", k, in_rdy); end
                    checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL bp_out_val[%0d]: got %0b want 1", k, out_val); end
                    checks++; if (out_ix !== 9'h002 || out_iy !== 9'h000) begin errors++; $display("FAIL bp_hold[%0d]: ix=%h iy=%h want 002/000", k, out_ix, out_iy); end
                    @(posedge clk); #1;
                end
                out_rdy = 1'b1;
            end
        join
        drain();
        checks++; if (q_ix.size() !== 9) begin errors++; $display("FAIL bp_count: got %0d want 9", q_ix.size()); end
        for (int i = 0; i < q_ix.size(); i++) begin
            checks++; if (q_ix[i] !== 9'h002 || q_iy[i] !== 9'h000) begin errors++; $display("FAIL bp_val[%0d]: ix=%h iy=%h want 002/000", i, q_ix[i], q_iy[i]); end
            checks++; if (q_last[i] !== (i == 8)) begin errors++; $display("FAIL bp_last[%0d]: got %0b want %0b", i, q_last[i], (i == 8)); end
        end
    endtask

    task automatic test_mid_reset();
        send_pixels(1, 7);
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL mrst_out_val: got %0b want 0", out_val); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL mrst_in_rdy: got %0b want 1", in_rdy); end
        clear_q();
        send_pixels(0, 25);
        drain();
        checks++; if (q_ix.size() !== 9) begin errors++; $display("FAIL mrst_count: got %0d want 9", q_ix.size()); end
        for (int i = 0; i < q_ix.size(); i++) begin
            checks++; if (q_ix[i] !== 9'h002 || q_iy[i] !== 9'h000) begin errors++; $display("FAIL mrst_val[%0d]: ix=%h iy=%h want 002/000", i, q_ix[i], q_iy[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int n_last;
        clear_q();
        stalls = 0;
        send_pixels(3, 50);
        checks++; if (stalls !== 0) begin errors++; $display("FAIL b2b_stalls: got %0d want 0", stalls); end
        drain();
        checks++; if (q_ix.size() !== 18) begin errors++; $display("FAIL b2b_count: got %0d want 18", q_ix.size()); end
        n_last = 0;
        for (int i = 0; i < q_ix.size(); i++) begin
            logic [DW:0] exp_ix;
            logic [DW:0] exp_iy;
            exp_ix = (i < 9) ? 9'h002 : 9'h000;
            exp_iy = (i < 9) ? 9'h000 : 9'h014;
            if (q_last[i]) n_last++;
            checks++; if (q_ix[i] !== exp_ix || q_iy[i] !== exp_iy) begin errors++; $display("FAIL b2b_val[%0d]: ix=%h iy=%h want %h/%h", i, q_ix[i], q_iy[i], exp_ix, exp_iy); end
            checks++; if (q_last[i] !== (i == 8 || i == 17)) begin errors++; $display("FAIL b2b_last[%0d]: got %0b want %0b", i, q_last[i], (i == 8 || i == 17)); end
        end
        checks++; if (n_last !== 2) begin errors++; $display("FAIL b2b_last_total: got %0d want 2", n_last); end
    endtask

    initial begin
        test_reset();
        test_ramp_x();
        test_ramp_y();
        test_col_edge();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
